// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per clock for rounds 0..10, driven by an
// external round-constant source started on the same start pulse.

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^(2+4+...+128); maps 0 to 0 naturally.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = ginv(in_i);
        out_o = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [31:0]  rcon_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t;
    logic [31:0]  n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w3[8*g +: 8]),
            .out_o (sub_w3[8*g +: 8])
        );
    end

    assign t  = sub_w3 ^ rcon_in;
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block can leave one unassigned and infer a latch.
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        if (start) begin
            state_d = RUN;
            key_d   = key_in;
            idx_d   = 4'd0;
        end else if (state_q == RUN) begin
            if (idx_q != LAST_ROUND) begin
                key_d  = {n0, n1, n2, n3};
                idx_d  = idx_q + 4'd1;
                done_d = (idx_q == LAST_ROUND - 4'd1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with a small model of the round-constant
// source started alongside it.

module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  rcon_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_pass = 0;
    int n_total = 0;

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rcon_in   (rcon_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Round-constant source: 0x01 at the first RUN edge, doubling in GF(2^8).
    logic [7:0] rc_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rc_q <= 8'h00;
        else if (start) rc_q <= 8'h01;
        else            rc_q <= {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
    end
    assign rcon_in = {rc_q, 24'h000000};

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };
    localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic launch(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " round_key"}, round_key, '0);
        check({tag, " round_idx"}, 128'(round_idx), 128'd0);
        check({tag, " key_valid"}, 128'(key_valid), 128'd0);
        check({tag, " busy"},      128'(busy), 128'd0);
        check({tag, " done"},      128'(done), 128'd0);
    endtask

    int valid_cnt, busy_cnt, done_cnt;

    initial begin
        for (int r = 0; r <= 10; r++) vecs[r] = '{FIPS_KEY, r, FIPS_RK[r]};
        vecs[11] = '{128'd0, 0, 128'd0};
        vecs[12] = '{128'd0, 1, ZERO_R1};
        vecs[13] = '{128'd0, 10, ZERO_R10};

        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single FIPS run with handshake counting through E12.
        launch(FIPS_KEY);
        check("e0 key", round_key, FIPS_KEY);
        check("e0 idx", 128'(round_idx), 128'd0);
        check("e0 valid", 128'(key_valid), 128'd1);
        check("e0 busy", 128'(busy), 128'd1);
        check("e0 done", 128'(done), 128'd0);
        valid_cnt = int'(key_valid);
        busy_cnt  = int'(busy);
        done_cnt  = int'(done);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("run1 key r%0d", k), round_key, FIPS_RK[k]);
            check($sformatf("run1 idx r%0d", k), 128'(round_idx), 128'(k));
            check($sformatf("run1 done r%0d", k), 128'(done), 128'(k == 10));
            valid_cnt += int'(key_valid);
            busy_cnt  += int'(busy);
            done_cnt  += int'(done);
        end
        for (int k = 11; k <= 12; k++) begin
            tick();
            check($sformatf("e%0d valid", k), 128'(key_valid), 128'd0);
            check($sformatf("e%0d busy", k), 128'(busy), 128'd0);
            check($sformatf("e%0d done", k), 128'(done), 128'd0);
            check($sformatf("e%0d idx hold", k), 128'(round_idx), 128'd10);
            check($sformatf("e%0d key hold", k), round_key, FIPS_RK[10]);
            valid_cnt += int'(key_valid);
            busy_cnt  += int'(busy);
            done_cnt  += int'(done);
        end
        check("valid cycles", 128'(valid_cnt), 128'd11);
        check("busy cycles", 128'(busy_cnt), 128'd11);
        check("done cycles", 128'(done_cnt), 128'd1);

        // Table of {key, rounds to advance, expected key}.
        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].key);
            repeat (vecs[i].round) tick();
            check($sformatf("vec%0d key", i), round_key, vecs[i].exp);
            check($sformatf("vec%0d idx", i), 128'(round_idx), 128'(vecs[i].round));
        end

        // Restart at round 5 with the all-zero key.
        launch(FIPS_KEY);
        repeat (5) tick();
        launch(128'd0);
        check("rst5 idx", 128'(round_idx), 128'd0);
        check("rst5 busy", 128'(busy), 128'd1);
        check("rst5 key", round_key, 128'd0);
        done_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1)  check("rst5 r1", round_key, ZERO_R1);
            if (k == 10) check("rst5 r10", round_key, ZERO_R10);
            if (k < 10)  done_cnt += int'(done);
            check($sformatf("rst5 busy r%0d", k), 128'(busy), 128'd1);
        end
        check("rst5 early done", 128'(done_cnt), 128'd0);
        check("rst5 final done", 128'(done), 128'd1);

        // Restart on the E10 edge suppresses done.
        launch(FIPS_KEY);
        repeat (9) tick();
        launch(128'd0);
        check("e10 restart done", 128'(done), 128'd0);
        check("e10 restart idx", 128'(round_idx), 128'd0);
        check("e10 restart busy", 128'(busy), 128'd1);

        // Asynchronous reset between edges at round 3.
        launch(FIPS_KEY);
        repeat (3) tick();
        check("pre-reset r3", round_key, FIPS_RK[3]);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle_zero("post reset");

        // start held for three edges.
        start  = 1'b1;
        key_in = FIPS_KEY;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold idx %0d", k), 128'(round_idx), 128'd0);
            check($sformatf("hold key %0d", k), round_key, FIPS_KEY);
        end
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("hold run key r%0d", k), round_key, FIPS_RK[k]);
            check($sformatf("hold run done r%0d", k), 128'(done), 128'(k == 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
